// File: rtl/mul_pkg.sv
// Shared types and sizing constants for the sequential sign-magnitude multiplier.
`default_nettype none

package mul_pkg;

  localparam int MUL_WIDTH = 8;
  // Counter needs to hold WIDTH-1 with headroom for one extra bit.
  localparam int CNT_W = $clog2(MUL_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sm_convert.sv
// Combinational two's-complement <-> sign/magnitude conversion.
// to_tc=0: out is |value| (the magnitude of a two's-complement input).
// to_tc=1: out is value negated when sign=1 (magnitude back to two's complement).
`default_nettype none

module sm_convert #(
  parameter int W = 8
) (
  input  logic         to_tc,
  input  logic         sign,
  input  logic [W-1:0] value,
  output logic [W-1:0] out_value
);

  logic neg;

  assign neg       = to_tc ? sign : value[W-1];
  // The most negative input maps to itself, which is the correct unsigned magnitude.
  assign out_value = neg ? (~value + W'(1)) : value;

endmodule

`default_nettype wire

// File: rtl/signed_magnitude_seq_multiplier.sv
// Sequential signed multiplier: operands split into sign/magnitude, magnitudes
// multiplied by one-bit-per-cycle shift-add, product negated when signs differ.
`default_nettype none

module signed_magnitude_seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy,
  output logic                 done
);

  state_t               state, state_next;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   res_tc;
  logic [CNT_W-1:0]     count;
  logic                 sign_r;
  logic                 last;

  sm_convert #(.W(WIDTH)) u_conv_a (
    .to_tc     (1'b0),
    .sign      (1'b0),
    .value     (A),
    .out_value (mag_a)
  );

  sm_convert #(.W(WIDTH)) u_conv_b (
    .to_tc     (1'b0),
    .sign      (1'b0),
    .value     (B),
    .out_value (mag_b)
  );

  // Negating a zero product yields zero, so there is no negative zero.
  sm_convert #(.W(2*WIDTH)) u_conv_res (
    .to_tc     (1'b1),
    .sign      (sign_r),
    .value     (acc_next),
    .out_value (res_tc)
  );

  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign last     = (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = CALC;
      CALC: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      sign_r <= 1'b0;
      result <= '0;
    end else if (state == IDLE && start) begin
      mcand  <= {{WIDTH{1'b0}}, mag_a};
      mplier <= mag_b;
      acc    <= '0;
      count  <= '0;
      sign_r <= A[WIDTH-1] ^ B[WIDTH-1];
    end else if (state == CALC) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CNT_W'(1);
      if (last) result <= res_tc;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_signed_magnitude_seq_multiplier.sv
// Self-checking bench: directed and random operands against an integer-arithmetic model.
`default_nettype none

module tb_signed_magnitude_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  A, B;
  logic [15:0] result;
  logic        busy, done;

  int checks = 0;
  int errors = 0;
  logic [15:0] prev_res = 16'h0000;

  signed_magnitude_seq_multiplier #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A      (A),
    .B      (B),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  // Drives one operation and reports what was observed; callers judge it.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output int bcyc, output int dcnt, output logic [15:0] res,
                        output logic [15:0] res_hold, output logic [15:0] res_during,
                        output bit overlap, output bit tmo);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = 8'($urandom); B = 8'($urandom);
    bcyc = 0; dcnt = 0; overlap = 0; tmo = 1; res = 'x; res_hold = 'x;
    res_during = result;
    for (int i = 0; i < 30; i++) begin
      if (busy && done) overlap = 1;
      if (busy) bcyc++;
      if (done) begin
        dcnt++;
        res = result;
        tmo = 0;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (done) dcnt++;
    res_hold = result;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h want 0000", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    rst_n = 1'b1;
    prev_res = 16'h0000;
  endtask

  task automatic test_directed;
    logic [7:0] ta [12] = '{8'd5, 8'd7, 8'hFA, 8'hF8, 8'd0, 8'hF7, 8'h80, 8'h80, 8'd127, 8'd1, 8'hFF, 8'd0};
    logic [7:0] tb [12] = '{8'd3, 8'hFC, 8'd5, 8'hFE, 8'd9, 8'd0, 8'h80, 8'd127, 8'd127, 8'hFF, 8'hFF, 8'h80};
    int bcyc, dcnt; logic [15:0] res, hold, during, exp; bit ov, tmo;
    for (int i = 0; i < 12; i++) begin
      exp = model(ta[i], tb[i]);
      run_op(ta[i], tb[i], bcyc, dcnt, res, hold, during, ov, tmo);
      checks++; if (tmo) begin errors++; $display("FAIL dir%0d_timeout: no done within 30 cycles", i); end
      checks++; if (res !== exp) begin errors++; $display("FAIL dir%0d_result: A=%h B=%h got %h want %h", i, ta[i], tb[i], res, exp); end
      checks++; if (hold !== exp) begin errors++; $display("FAIL dir%0d_hold: got %h want %h", i, hold, exp); end
      checks++; if (bcyc !== 8) begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d want 8", i, bcyc); end
      checks++; if (dcnt !== 1) begin errors++; $display("FAIL dir%0d_done_pulses: got %0d want 1", i, dcnt); end
      checks++; if (ov) begin errors++; $display("FAIL dir%0d_busy_done_overlap: got 1 want 0", i); end
      checks++; if (during !== prev_res) begin errors++; $display("FAIL dir%0d_result_during_busy: got %h want %h", i, during, prev_res); end
      prev_res = exp;
    end
  endtask

  task automatic test_random;
    int bcyc, dcnt; logic [15:0] res, hold, during, exp; bit ov, tmo;
    logic [7:0] a, b;
    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      if ($urandom_range(0, 5) == 0) a = 8'h80;
      exp = model(a, b);
      run_op(a, b, bcyc, dcnt, res, hold, during, ov, tmo);
      checks++; if (res !== exp) begin errors++; $display("FAIL rnd%0d_result: A=%h B=%h got %h want %h", i, a, b, res, exp); end
      checks++; if (bcyc !== 8 || dcnt !== 1 || ov || tmo) begin errors++; $display("FAIL rnd%0d_handshake: busy=%0d done=%0d overlap=%0d timeout=%0d want 8/1/0/0", i, bcyc, dcnt, ov, tmo); end
      prev_res = exp;
    end
  endtask

  task automatic test_start_while_busy;
    int dcnt = 0, bcyc = 0; logic [15:0] res = 'x;
    @(negedge clk);
    A = 8'd7; B = 8'hFC; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = 8'd3; B = 8'd3;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Window covers the remainder of one operation plus ample slack for a spurious second one.
    for (int i = 0; i < 25; i++) begin
      if (busy) bcyc++;
      if (done) begin dcnt++; res = result; end
      @(negedge clk);
    end
    checks++; if (res !== 16'hFFE4) begin errors++; $display("FAIL busy_start_result: got %h want ffe4", res); end
    checks++; if (dcnt !== 1) begin errors++; $display("FAIL busy_start_done_pulses: got %0d want 1", dcnt); end
    checks++; if (bcyc !== 5) begin errors++; $display("FAIL busy_start_busy_cycles: got %0d want 5", bcyc); end
    prev_res = 16'hFFE4;
  endtask

  task automatic test_start_held;
    logic [15:0] res = 'x; bit seen = 0;
    @(negedge clk);
    A = 8'hFA; B = 8'd5; start = 1'b1;
    @(negedge clk);
    A = 8'hF8; B = 8'hFE;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (done) begin seen = 1; res = result; end
      else @(negedge clk);
    end
    checks++; if (!seen || res !== 16'hFFE2) begin errors++; $display("FAIL held_first_result: got %h want ffe2 (seen=%0d)", res, seen); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL held_idle_gap: busy=%b done=%b want 0/0", busy, done); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL held_accept_from_idle: busy=%b want 1", busy); end
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (done) begin seen = 1; res = result; end
      else @(negedge clk);
    end
    checks++; if (!seen || res !== 16'h0010) begin errors++; $display("FAIL held_second_result: got %h want 0010 (seen=%0d)", res, seen); end
    prev_res = 16'h0010;
  endtask

  task automatic test_reset_mid;
    int bcyc, dcnt; logic [15:0] res, hold, during; bit ov, tmo;
    @(negedge clk);
    A = 8'd100; B = 8'hFD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: busy=%b done=%b want 0/0", busy, done); end
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL mid_reset_result: got %h want 0000", result); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset_held: busy=%b done=%b want 0/0", busy, done); end
    rst_n = 1'b1;
    prev_res = 16'h0000;
    run_op(8'd5, 8'd3, bcyc, dcnt, res, hold, during, ov, tmo);
    checks++; if (res !== 16'h000F || tmo) begin errors++; $display("FAIL post_reset_result: got %h want 000f (timeout=%0d)", res, tmo); end
    checks++; if (bcyc !== 8 || dcnt !== 1) begin errors++; $display("FAIL post_reset_latency: busy=%0d done=%0d want 8/1", bcyc, dcnt); end
    checks++; if (during !== 16'h0000) begin errors++; $display("FAIL post_reset_during: got %h want 0000", during); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_start_while_busy;
    test_start_held;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/signed_magnitude_seq_multiplier.md
Name: signed_magnitude_seq_multiplier

Overview:
Sequential 8x8 signed multiplier using the sign-magnitude method.
- Operands arrive in two's complement. Each operand is split into a sign bit and a magnitude.
- The magnitudes are multiplied unsigned by shift-add, one bit per clock. The product is then negated if the operand signs differ.
- Sits in the execution unit as the multi-cycle MUL resource, controlled by a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand width in bits. The result is 2*WIDTH bits wide.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse. Sampled on the rising edge; accepted only in IDLE.
- A  input  WIDTH  multiplicand, two's complement.
- B  input  WIDTH  multiplier, two's complement.
- result  output  2*WIDTH  product, two's complement. Registered and held until the next accepted start.
- busy  output  1  high while the iterations run.
- done  output  1  one-cycle pulse when result becomes valid.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, result=0, busy=0, done=0, internal registers=0. Reset asserted mid-operation aborts immediately; no done is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - On an edge with start=1, latch the operands. mag_a = |A| and mag_b = |B| as unsigned WIDTH-bit values.
  - -128 gives magnitude 128. This fits unsigned 8 bits; no overflow.
  - Latch sign_r = A[MSB] XOR B[MSB]. Clear the accumulator and iteration counter. Go to CALC.
- CALC:
  - busy=1 in every CALC cycle.
  - Each edge: if the multiplier LSB is 1, add the multiplicand (shifted by the iteration index) into the 2*WIDTH accumulator. Then shift the multiplier right and increment the counter.
  - After exactly WIDTH iterations, go to DONE.
  - On the final iteration edge, write result = sign_r ? -product : product.
  - If the product is 0, result is 0 regardless of sign; there is no negative zero.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then return to IDLE.
- Latency: the start-accept edge is E0. busy is high for cycles E0..E8 (8 cycles), result is valid after E8, and done is high during the cycle after E8.
- start while busy or during DONE is ignored. Operands are not re-sampled.
- A and B may change freely after the accept edge.
- result holds its value through IDLE until the next product is written. It is not cleared on start.
- Range: full-range products fit in 16 bits. -128*-128 = +16384 and -128*127 = -16256; no overflow flag.
- busy and done are never high together.

Decomposition:
- Shared package mul_pkg:
  - state enum (IDLE, CALC, DONE);
  - WIDTH default constant;
  - iteration-counter width constant clog2(WIDTH)+1.
- One natural sub-module: sm_convert, combinational two's-complement <-> sign/magnitude conversion. It is used for both the operand split and the final result negation.
- The control FSM and shift-add datapath stay in the top module.

Test Plan:
- A=5, B=3 -> busy for 8 cycles, done one cycle, result=15 (0x000F). result still 15 on the next cycle.
- A=7, B=-4 -> result=-28 (0xFFE4). A=-6, B=5 -> result=-30 (0xFFE2).
- A=-8, B=-2 -> result=16. A=0, B=9 -> 0. A=-9, B=0 -> 0x0000 (no negative zero).
- Extremes: A=-128, B=-128 -> 16384 (0x4000). A=-128, B=127 -> -16256 (0xC080). A=127, B=127 -> 16129.
- Handshake: pulse start again while busy with different operands -> ignored, original product returned, done pulses once. Start held high across DONE -> the next operation is accepted only from IDLE.
- Reset: drop rst_n at iteration 4 -> busy, done and result go to 0 asynchronously. After release, A=5, B=3 -> 15 with normal latency.
